// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and receiver mode codes for the serial link
//
// Purpose: serializer state encoding and the shift_reg mode encodings the
// transmitter is designed to pair with (MSB-first -> LEFT, LSB-first -> RIGHT).
// Ports: none (package).
package shift_pkg;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_SHIFT = 2'd1,
        SER_DONE  = 2'd2
    } ser_state_t;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_RIGHT = 2'b11;

endpackage

// File: rtl/ser_bit_cnt.sv
// rtl/ser_bit_cnt.sv - frame bit counter with clear, enable and last-bit flag
//
// Purpose: counts bits shifted in the current frame.
// Ports:
//   clk     in  system clock
//   nrst    in  asynchronous active-low reset
//   clr_i   in  restart count at zero (wins over en_i)
//   en_i    in  advance count by one
//   last_o  out count equals WIDTH-1 (next advance ends the frame)
module ser_bit_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in / serial-out transmitter
//
// Purpose: accepts a WIDTH-bit word via valid/ready and shifts it out one bit
// per bit_tick_i, MSB-first or LSB-first, with a one-cycle done pulse.
// Ports:
//   clk           in   system clock
//   nrst          in   asynchronous active-low reset
//   par_i         in   word to transmit
//   lsb_first_i   in   bit order (1 = LSB first), sampled at load
//   load_valid_i  in   par_i/lsb_first_i valid
//   load_ready_o  out  idle, can accept a word
//   bit_tick_i    in   advance one bit (level, sampled each clock)
//   ser_o         out  serial data, 0 when ser_valid_o is 0
//   ser_valid_o   out  ser_o holds a frame bit
//   busy_o        out  frame in progress
//   done_o        out  one-cycle pulse after the last bit
module piso_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] par_i,
    input  logic             lsb_first_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic             bit_tick_i,
    output logic             ser_o,
    output logic             ser_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             order_q, order_d;

    logic capture;
    logic advance;
    logic last_bit;

    // Ticks are only meaningful in SHIFT; a tick on the capture cycle is dropped.
    assign capture = (state_q == SER_IDLE) && load_valid_i;
    assign advance = (state_q == SER_SHIFT) && bit_tick_i;

    ser_bit_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk    (clk),
        .nrst   (nrst),
        .clr_i  (capture),
        .en_i   (advance),
        .last_o (last_bit)
    );

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= SER_IDLE;
            shreg_q <= '0;
            order_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            order_q <= order_d;
        end
    end

    // Next state and datapath
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        order_d = order_q;
        case (state_q)
            SER_IDLE: begin
                if (capture) begin
                    shreg_d = par_i;
                    order_d = lsb_first_i;
                    state_d = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (advance) begin
                    shreg_d = order_q ? (shreg_q >> 1) : (shreg_q << 1);
                    if (last_bit) begin
                        state_d = SER_DONE;
                    end
                end
            end
            SER_DONE: begin
                state_d = SER_IDLE;
            end
            default: begin
                state_d = SER_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        load_ready_o = 1'b0;
        ser_valid_o  = 1'b0;
        ser_o        = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            SER_IDLE: begin
                load_ready_o = 1'b1;
            end
            SER_SHIFT: begin
                ser_valid_o = 1'b1;
                busy_o      = 1'b1;
                ser_o       = order_q ? shreg_q[0] : shreg_q[WIDTH-1];
            end
            SER_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
                load_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] par_i = 8'h00;
    logic       lsb_first_i = 1'b0;
    logic       load_valid_i = 1'b0;
    logic       load_ready_o;
    logic       bit_tick_i = 1'b0;
    logic       ser_o;
    logic       ser_valid_o;
    logic       busy_o;
    logic       done_o;

    piso_serializer #(.WIDTH(8)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .par_i        (par_i),
        .lsb_first_i  (lsb_first_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .bit_tick_i   (bit_tick_i),
        .ser_o        (ser_o),
        .ser_valid_o  (ser_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic       exp_q[$];
    logic [7:0] rx = 8'h00;
    logic       rx_lsb = 1'b0;
    int         done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w, input logic lsb);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(lsb ? w[i] : w[7-i]);
        end
    endtask

    // Observe the current cycle (receiver model + scoreboard), then advance one clock.
    task automatic step();
        logic e;
        if (nrst && ser_valid_o && bit_tick_i) begin
            if (exp_q.size() == 0) begin
                chk("extra_bit", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ser_bit", {31'd0, ser_o}, {31'd0, e});
            end
            rx = rx_lsb ? {ser_o, rx[7:1]} : {rx[6:0], ser_o};
        end
        if (!ser_valid_o) chk("ser_zero_when_invalid", {31'd0, ser_o}, 32'd0);
        if (busy_o) chk("ready_low_when_busy", {31'd0, load_ready_o}, 32'd0);
        if (done_o) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] w, input logic lsb, input logic keep_valid);
        chk("ready_before_load", {31'd0, load_ready_o}, 32'd1);
        par_i = w;
        lsb_first_i = lsb;
        load_valid_i = 1'b1;
        push_word(w, lsb);
        rx = 8'h00;
        rx_lsb = lsb;
        step();
        load_valid_i = keep_valid;
        bit_tick_i = 1'b0;
    endtask

    // Tick every 'period' clocks until done_o is seen; returns the cycle index of
    // the done pulse (relative to the first tick cycle) and the bits consumed.
    task automatic run(input int period, output int done_at, output int n_ticks);
        logic prev_tick;
        logic prev_ser;
        logic seen;
        done_at = -1;
        n_ticks = 0;
        prev_tick = 1'b1;
        prev_ser = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bit_tick_i = ((c % period) == 0);
            if (!prev_tick && ser_valid_o) chk("ser_stable", {31'd0, ser_o}, {31'd0, prev_ser});
            if (ser_valid_o && bit_tick_i) n_ticks++;
            prev_tick = bit_tick_i;
            prev_ser = ser_o;
            seen = done_o;
            step();
            if (seen) begin
                done_at = c;
                break;
            end
        end
        bit_tick_i = 1'b0;
        if (done_at < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int d_at;
        int nt;
        int dc0;

        // 1. Reset state, then reset mid-frame
        @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, load_ready_o}, 32'd1);
        chk("rst_ser_valid", {31'd0, ser_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        nrst = 1'b1;
        step();
        load(8'h77, 1'b0, 1'b0);
        chk("shift_busy", {31'd0, busy_o}, 32'd1);
        bit_tick_i = 1'b1;
        step();
        step();
        step();
        #2;
        nrst = 1'b0;
        #1;
        chk("midrst_ser_valid", {31'd0, ser_valid_o}, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_ready", {31'd0, load_ready_o}, 32'd1);
        bit_tick_i = 1'b0;
        dc0 = done_cnt;
        step();
        nrst = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("midrst_no_done", done_cnt - dc0, 32'd0);
        chk("midrst_still_idle", {31'd0, load_ready_o}, 32'd1);
        exp_q.delete();

        // 2. MSB first, tick every clock
        dc0 = done_cnt;
        load(8'hAA, 1'b0, 1'b0);
        run(1, d_at, nt);
        chk("msb_done_once", done_cnt - dc0, 32'd1);
        chk("msb_rx", {24'd0, rx}, 32'h0000_00AA);
        chk("msb_queue_empty", exp_q.size(), 32'd0);
        chk("msb_ticks", nt, 32'd8);

        // 3. LSB first, receiver in RIGHT mode
        dc0 = done_cnt;
        load(8'hAA, 1'b1, 1'b0);
        run(1, d_at, nt);
        chk("lsb_done_once", done_cnt - dc0, 32'd1);
        chk("lsb_rx", {24'd0, rx}, 32'h0000_00AA);
        chk("lsb_queue_empty", exp_q.size(), 32'd0);

        // 4. Sparse ticks: last tick lands 3*7 clocks after the first, done one clock later
        dc0 = done_cnt;
        load(8'hC3, 1'b0, 1'b0);
        run(3, d_at, nt);
        chk("sparse_done_latency", d_at, 32'd22);
        chk("sparse_rx", {24'd0, rx}, 32'h0000_00C3);
        chk("sparse_done_once", done_cnt - dc0, 32'd1);

        // 5. Valid held across two frames
        dc0 = done_cnt;
        load(8'h01, 1'b0, 1'b1);
        par_i = 8'hFE;
        push_word(8'hFE, 1'b0);
        run(1, d_at, nt);
        chk("hs_ready_after_done", {31'd0, load_ready_o}, 32'd1);
        chk("hs_rx_first", {24'd0, rx}, 32'h0000_0001);
        rx = 8'h00;
        step();
        chk("hs_second_captured", {31'd0, ser_valid_o}, 32'd1);
        load_valid_i = 1'b0;
        run(1, d_at, nt);
        chk("hs_rx_second", {24'd0, rx}, 32'h0000_00FE);
        chk("hs_done_twice", done_cnt - dc0, 32'd2);
        chk("hs_queue_empty", exp_q.size(), 32'd0);

        // 6. Tick on capture cycle and par_i change during SHIFT are ignored
        bit_tick_i = 1'b1;
        load(8'h5A, 1'b0, 1'b0);
        par_i = 8'h00;
        lsb_first_i = 1'b1;
        run(1, d_at, nt);
        chk("ign_ticks", nt, 32'd8);
        chk("ign_rx", {24'd0, rx}, 32'h0000_005A);
        chk("ign_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
